// File: rtl/intcheck_arbiter.sv
// intcheck_arbiter: shares one intcheck declaration checker between two
// character-stream requesters. A granted statement is buffered up to ';',
// the checker is cleared, the statement is replayed gap-free, and the
// sampled verdict is handed back to the owning requester.
module intcheck_arbiter #(
  parameter int DEPTH   = 16,  // statement buffer size in chars, ';' included (>= 2)
  parameter int RES_LAT = 1    // cycles from the ';' drive cycle to the chk_out sample (>= 1)
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [1:0] res_valid,
  output logic       res_ok,
  output logic       res_ovf,
  input  logic [1:0] res_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       chk_rst,
  output logic [7:0] chk_in,
  input  logic       chk_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(RES_LAT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [LW-1:0] LAT_MAX = LW'(RES_LAT);
  localparam logic [LW-1:0] LAT_ONE = LW'(1);
  localparam logic [7:0]    SEMI    = 8'h3B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_PLAY,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            ptr_q, ptr_d;       // 0: s0 wins a tie, 1: s1 wins a tie
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   rd_q, rd_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            ovf_q, ovf_d;
  logic            ok_q, ok_d;
  logic [DEPTH-1:0][7:0] mem_q;

  // Requesters viewed as a packed pair so per-side logic is one loop.
  logic [1:0][7:0] req_data;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [7:0]      sel_data;
  logic            sel_valid;
  logic            acc;
  logic            is_semi;
  logic            res_ack;
  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            last_rd;

  assign req_data  = {s1_data, s0_data};
  assign req_valid = {s1_valid, s0_valid};

  for (genvar r = 0; r < 2; r++) begin : g_req
    assign req_ready[r] = (state_q == S_LOAD) & grant_q[r];
    assign res_valid[r] = (state_q == S_RESP) & grant_q[r];
  end

  assign s0_ready  = req_ready[0];
  assign s1_ready  = req_ready[1];
  assign sel_valid = |(req_valid & grant_q);
  assign sel_data  = grant_q[1] ? req_data[1] : req_data[0];
  assign acc       = (state_q == S_LOAD) & sel_valid;
  assign is_semi   = (sel_data == SEMI);
  // Only the owner's acknowledge retires a result.
  assign res_ack   = (state_q == S_RESP) & |(res_ready & grant_q);

  assign wr_idx  = cnt_q[AW-1:0];
  assign rd_idx  = rd_q[AW-1:0];
  // The buffered ';' is always the last entry, so replay ends at cnt-1.
  assign last_rd = (rd_q == cnt_q - CNT_ONE);

  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);
  assign chk_rst = (state_q == S_CLR);
  assign chk_in  = (state_q == S_PLAY) ? mem_q[rd_idx] : 8'h00;
  assign res_ok  = (state_q == S_RESP) & ok_q;
  assign res_ovf = (state_q == S_RESP) & ovf_q;

  // Next-state and datapath control for the grant/load/replay/respond cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    lat_d   = lat_q;
    ovf_d   = ovf_q;
    ok_d    = ok_q;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (s0_valid && s1_valid) begin
          grant_d = ptr_q ? 2'b10 : 2'b01;
          state_d = S_LOAD;
        end else if (s0_valid) begin
          grant_d = 2'b01;
          state_d = S_LOAD;
        end else if (s1_valid) begin
          grant_d = 2'b10;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (acc) begin
          if (is_semi) begin
            if (ovf_q || cnt_q == CNT_MAX) begin
              // Too long to hold: report overflow without consulting the checker.
              ovf_d   = 1'b1;
              ok_d    = 1'b0;
              state_d = S_RESP;
            end else begin
              wr_en   = 1'b1;
              cnt_d   = cnt_q + CNT_ONE;
              state_d = S_CLR;
            end
          end else if (cnt_q == CNT_MAX) begin
            // Buffer full: drop chars until the terminating ';'.
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_CLR: begin
        rd_d    = '0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        rd_d = rd_q + CNT_ONE;
        if (last_rd) begin
          // The ';' drive cycle is cycle 0 of the result latency.
          lat_d   = LAT_ONE;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_MAX) begin
          ok_d    = chk_out;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q + LAT_ONE;
        end
      end
      S_RESP: begin
        if (res_ack) begin
          ptr_d   = grant_q[0];
          grant_d = 2'b00;
          cnt_d   = '0;
          rd_d    = '0;
          ovf_d   = 1'b0;
          ok_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Control state; reset discards any statement in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      lat_q   <= '0;
      ovf_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      lat_q   <= lat_d;
      ovf_q   <= ovf_d;
      ok_q    <= ok_d;
    end
  end

  // Statement buffer; contents are only meaningful below cnt, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= sel_data;
  end

endmodule
